p2s_scan_master: RTL

- Master-side sequencer for a chain of parallel-to-serial shift slaves on the board link.
- Generates the load strobe `sld_n` and the shift clock `sclk`, and samples the returned serial stream `si` LSB-first.
- Publishes the assembled word on `po` with a one-cycle valid strobe.
- Runs single-shot on request, or free-running with a programmable inter-frame gap.

---
 rtl/p2s_scan_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/p2s_scan_master.sv
// p2s_scan_master
// Master-side sequencer for a chain of parallel-to-serial shift slaves.
// A frame has four parts. First, sld_n is pulsed low so the slaves latch
// their parallel inputs. Next, a setup half-period lets the data settle.
// Then sclk is pulsed NBIT times, and the returned serial stream is sampled
// LSB-first. Finally, the assembled word is published on o_po with a
// one-cycle o_po_vld strobe.
// Frames run single-shot on request, or free-running with an idle gap.
//
// Optional build macro: P2S_SCAN_FILTER_EN
//   When it is defined, a frame is published only if it matches the frame
//   captured just before it (two-frame match).
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   i_scan_en   auto mode; frames repeat with SCAN_GAP idle cycles between them
//   i_scan_req  single-shot frame request (level, sampled)
//   i_si        serial data from the slave chain (asynchronous)
//   o_sclk      shift clock to the slaves (registered)
//   o_sld_n     active-low parallel load to the slaves (registered)
//   o_po        last published frame; bit 0 is the first serial bit
//   o_po_vld    one-cycle pulse when o_po updates
//   o_busy      high from LOAD through DONE
module p2s_scan_master #(
    parameter int NBIT      = 64,
    parameter int SCLK_HALF = 16,
    parameter int LD_CYC    = 4,
    parameter int SCAN_GAP  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_scan_en,
    input  logic            i_scan_req,
    input  logic            i_si,
    output logic            o_sclk,
    output logic            o_sld_n,
    output logic [NBIT-1:0] o_po,
    output logic            o_po_vld,
    output logic            o_busy
);

    localparam int BIT_W   = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam int CNT_MAX = (LD_CYC > SCLK_HALF) ? LD_CYC : SCLK_HALF;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_W   = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

    localparam logic [CNT_W-1:0] LD_LAST   = CNT_W'(LD_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NBIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(SCAN_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [GAP_W-1:0]  r_gap;
    logic              r_pending;
    logic              r_si_meta;
    logic              r_si_s;
    logic              r_sclk;
    logic              r_sld_n;
    logic [NBIT-1:0]   r_shreg;
    logic [NBIT-1:0]   r_po;
    logic              r_po_vld;
`ifdef P2S_SCAN_FILTER_EN
    logic [NBIT-1:0]   r_prev;
`endif

    logic w_ld_end;
    logic w_half_end;
    logic w_last_bit;
    logic w_gap_hit;
    logic w_trig;
    logic w_sclk_nxt;
    logic w_publish;

    always_comb begin
        w_next     = r_state;
        w_sclk_nxt = 1'b0;
        w_ld_end   = (r_cnt == LD_LAST);
        w_half_end = (r_cnt == HALF_LAST);
        w_last_bit = (r_bit == BIT_LAST);
        // The gap counter stops one short of SCAN_GAP, so that the cycle
        // that leaves IDLE is itself the SCAN_GAP-th idle cycle.
        w_gap_hit  = (r_gap == GAP_LAST);
        w_trig     = r_pending | i_scan_req | (i_scan_en & w_gap_hit);
`ifdef P2S_SCAN_FILTER_EN
        w_publish  = (r_shreg == r_prev);
`else
        w_publish  = 1'b1;
`endif
        case (r_state)
            S_IDLE:  if (w_trig) w_next = S_LOAD;
            S_LOAD:  if (w_ld_end) w_next = S_SETUP;
            S_SETUP: begin
                if (w_half_end) w_next = S_SHIFT;
                w_sclk_nxt = w_half_end;
            end
            S_SHIFT: begin
                if (w_half_end && !r_sclk && w_last_bit) w_next = S_DONE;
                // The end of a high phase drops sclk. The end of a low phase
                // raises it again, except after the final pulse.
                w_sclk_nxt = w_half_end ? (~r_sclk & ~w_last_bit) : r_sclk;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control state, strobes and the published word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_gap     <= '0;
            r_pending <= 1'b0;
            r_sclk    <= 1'b0;
            r_sld_n   <= 1'b1;
            r_po      <= '0;
            r_po_vld  <= 1'b0;
`ifdef P2S_SCAN_FILTER_EN
            r_prev    <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_sclk  <= w_sclk_nxt;
            r_sld_n <= (w_next != S_LOAD);

            if (r_state == S_IDLE || r_state == S_DONE || w_next != r_state ||
                (r_state == S_SHIFT && w_half_end))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_state != S_SHIFT)
                r_bit <= '0;
            else if (w_half_end && !r_sclk && !w_last_bit)
                r_bit <= r_bit + 1'b1;

            if (r_state == S_IDLE && w_next == S_IDLE) begin
                if (!w_gap_hit) r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end

            if (r_state == S_IDLE)
                r_pending <= 1'b0;
            else if (i_scan_req)
                r_pending <= 1'b1;

            r_po_vld <= (w_next == S_DONE) && w_publish;
            if ((w_next == S_DONE) && w_publish) r_po <= r_shreg;
`ifdef P2S_SCAN_FILTER_EN
            if (w_next == S_DONE) r_prev <= r_shreg;
`endif
        end
    end

    // Input synchroniser and capture shift register.
    // Every bit is rewritten in every frame, so these need no reset.
    always_ff @(posedge clk) begin
        r_si_meta <= i_si;
        r_si_s    <= r_si_meta;
        if (r_state == S_SHIFT && r_sclk && w_half_end)
            r_shreg[r_bit] <= r_si_s;
    end

    assign o_sclk   = r_sclk;
    assign o_sld_n  = r_sld_n;
    assign o_po     = r_po;
    assign o_po_vld = r_po_vld;
    assign o_busy   = (r_state != S_IDLE);

endmodule
